// File: rtl/mult_issue_ctrl.sv
// Issue/capture controller for a fixed-latency sequential multiplier core.
// Operand pairs queue in a small FIFO; one pair at a time is loaded, waited on and captured with its tag.
module mult_issue_ctrl #(
  parameter int DEPTH       = 4,
  parameter int MUL_LATENCY = 34,
  parameter int TAG_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_x,
  input  logic [31:0]       in_y,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              mul_load,
  output logic [31:0]       mul_x,
  output logic [31:0]       mul_y,
  input  logic [63:0]       mul_product,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [63:0]       out_product,
  output logic [TAG_W-1:0]  out_tag,
  output logic              busy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int LAT_W = $clog2(MUL_LATENCY + 2);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [31:0]        r_fifo_x   [DEPTH];
  logic [31:0]        r_fifo_y   [DEPTH];
  logic [TAG_W-1:0]   r_fifo_tag [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [LAT_W-1:0]   r_cnt;
  logic [TAG_W-1:0]   r_tag;
  logic               w_push;
  logic               w_pop;
  logic               w_latch;
  logic               w_capture;
  logic [31:0]        w_head_x;
  logic [31:0]        w_head_y;
  logic [TAG_W-1:0]   w_head_tag;

  assign in_ready  = rst && (r_count < CNT_W'(DEPTH));
  assign w_push    = in_valid && in_ready;
  assign w_pop     = (r_state == LOAD);
  assign mul_load  = (r_state == LOAD);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE) || (r_count != '0);

  // An empty FIFO can only be latched from DONE with a same-edge push, so forward the incoming pair.
  assign w_head_x   = (r_count == '0) ? in_x   : r_fifo_x[r_rd_ptr];
  assign w_head_y   = (r_count == '0) ? in_y   : r_fifo_y[r_rd_ptr];
  assign w_head_tag = (r_count == '0) ? in_tag : r_fifo_tag[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_x[r_wr_ptr]   <= in_x;
      r_fifo_y[r_wr_ptr]   <= in_y;
      r_fifo_tag[r_wr_ptr] <= in_tag;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_capture   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (r_count != '0) begin
          w_latch     = 1'b1;
          w_state_nxt = LOAD;
        end
      end
      LOAD: w_state_nxt = WAIT;
      WAIT: begin
        if (r_cnt == LAT_W'(MUL_LATENCY)) begin
          w_capture   = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          if ((r_count != '0) || w_push) begin
            w_latch     = 1'b1;
            w_state_nxt = LOAD;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (w_pop) begin
      r_cnt <= LAT_W'(1);
    end else if (w_capture) begin
      r_cnt <= '0;
    end else if (r_state == WAIT) begin
      r_cnt <= r_cnt + LAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_x       <= '0;
      mul_y       <= '0;
      r_tag       <= '0;
      out_product <= '0;
      out_tag     <= '0;
    end else begin
      if (w_latch) begin
        mul_x <= w_head_x;
        mul_y <= w_head_y;
        r_tag <= w_head_tag;
      end
      if (w_capture) begin
        out_product <= mul_product;
        out_tag     <= r_tag;
      end
    end
  end

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Scoreboard bench for mult_issue_ctrl: directed scenarios plus randomized traffic against a queue-based model.
module tb_mult_issue_ctrl;

  localparam int DEPTH       = 4;
  localparam int MUL_LATENCY = 34;
  localparam int TAG_W       = 4;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_x;
  logic [31:0]       in_y;
  logic [TAG_W-1:0]  in_tag;
  logic              mul_load;
  logic [31:0]       mul_x;
  logic [31:0]       mul_y;
  logic [63:0]       mul_product;
  logic              out_valid;
  logic              out_ready;
  logic [63:0]       out_product;
  logic [TAG_W-1:0]  out_tag;
  logic              busy;

  mult_issue_ctrl #(.DEPTH(DEPTH), .MUL_LATENCY(MUL_LATENCY), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y), .in_tag(in_tag),
    .mul_load(mul_load), .mul_x(mul_x), .mul_y(mul_y), .mul_product(mul_product),
    .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product), .out_tag(out_tag),
    .busy(busy)
  );

  typedef struct {
    logic [63:0]      prod;
    logic [TAG_W-1:0] tag;
    int               push_cyc;
    bit               chk_lat;
  } exp_t;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
  } op_t;

  exp_t exp_q[$];
  op_t  op_q[$];

  int n_cmp;
  int n_fail;
  int cyc;
  int tmo;
  bit fin;
  bit rnd_done;
  bit prev_load;
  bit prev_valid;
  bit expect_load;
  bit fin_done;
  logic [31:0] rx;
  logic [31:0] ry;
  logic [31:0] corner [4];

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Multiplier core model: product valid MUL_LATENCY edges after the load pulse ends, garbage before that.
  initial begin : core_model
    int ccnt;
    logic [31:0] cx;
    logic [31:0] cy;
    ccnt = 0;
    cx = '0;
    cy = '0;
    mul_product = '0;
    forever begin
      @(posedge clk);
      if (!rst) begin
        ccnt = 0;
      end else if (mul_load) begin
        cx = mul_x;
        cy = mul_y;
        ccnt = 1;
        mul_product <= {$urandom, $urandom};
      end else if (ccnt != 0) begin
        if (ccnt == MUL_LATENCY - 1) begin
          mul_product <= ref_mul(cx, cy);
          ccnt = 0;
        end else begin
          ccnt++;
        end
      end
    end
  end

  initial begin : monitor
    exp_t e;
    op_t  o;
    n_cmp = 0;
    n_fail = 0;
    prev_load = 1'b0;
    prev_valid = 1'b0;
    expect_load = 1'b0;
    fin_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_q.delete();
        op_q.delete();
        prev_load = 1'b0;
        prev_valid = 1'b0;
        expect_load = 1'b0;
        chk("reset_outputs",
            160'({mul_load, mul_x, mul_y, out_valid, out_product, out_tag, in_ready, busy}), 160'(0));
      end else begin
        chk("in_ready", 160'(in_ready), 160'(op_q.size() < DEPTH));
        if (expect_load) chk("load_after_accept", 160'(mul_load), 160'(1));
        expect_load = 1'b0;
        if (mul_load) begin
          chk("load_consecutive", 160'(prev_load), 160'(0));
          chk("load_while_valid", 160'(out_valid), 160'(0));
          chk("load_has_request", 160'(op_q.size() != 0), 160'(1));
          if (op_q.size() != 0) begin
            o = op_q.pop_front();
            chk("mul_x", 160'(mul_x), 160'(o.x));
            chk("mul_y", 160'(mul_y), 160'(o.y));
          end
        end
        if (out_valid) begin
          chk("result_expected", 160'(exp_q.size() != 0), 160'(1));
          if (exp_q.size() != 0) begin
            e = exp_q[0];
            if (!prev_valid && e.chk_lat)
              chk("latency", 160'(cyc - e.push_cyc), 160'(MUL_LATENCY + 2));
            chk("out_product", 160'(out_product), 160'(e.prod));
            chk("out_tag", 160'(out_tag), 160'(e.tag));
            if (out_ready) begin
              void'(exp_q.pop_front());
              expect_load = (op_q.size() != 0) || (in_valid && in_ready);
            end
          end
        end
        prev_load = mul_load;
        prev_valid = out_valid;
      end
      if (fin && !fin_done) begin
        fin_done = 1'b1;
        chk("timeouts", 160'(tmo), 160'(0));
        chk("results_outstanding", 160'(exp_q.size()), 160'(0));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [31:0] x, input logic [31:0] y,
                      input logic [TAG_W-1:0] t, input logic [63:0] p);
    int w;
    bit idle;
    in_valid = 1'b1;
    in_x = x;
    in_y = y;
    in_tag = t;
    w = 0;
    while (!in_ready && w < 300) begin
      tick(1);
      w++;
    end
    if (!in_ready) begin
      tmo++;
    end else begin
      idle = !busy;
      tick(1);
      op_q.push_back('{x: x, y: y});
      exp_q.push_back('{prod: p, tag: t, push_cyc: cyc, chk_lat: idle});
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int max);
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < max) begin
      tick(1);
      w++;
    end
    if (exp_q.size() != 0) tmo++;
  endtask

  task automatic wait_valid(input int max);
    int w;
    w = 0;
    while (!out_valid && w < max) begin
      tick(1);
      w++;
    end
    if (!out_valid) tmo++;
  endtask

  initial begin : stimulus
    corner[0] = 32'h8000_0000;
    corner[1] = 32'h7FFF_FFFF;
    corner[2] = 32'hFFFF_FFFF;
    corner[3] = 32'h0000_0000;
    tmo = 0;
    fin = 1'b0;
    rnd_done = 1'b0;
    rst = 1'b0;
    in_valid = 1'b0;
    in_x = '0;
    in_y = '0;
    in_tag = '0;
    out_ready = 1'b0;
    rx = '0;
    ry = '0;
    tick(3);
    rst = 1'b1;
    tick(2);

    // Single request and signed operands.
    out_ready = 1'b1;
    send(32'd7, 32'd6, 4'd3, 64'h0000_0000_0000_002A);
    wait_drain(100);
    send(32'hFFFF_FFFD, 32'd5, 4'd1, 64'hFFFF_FFFF_FFFF_FFF1);
    wait_drain(100);
    send(32'h8000_0000, 32'h8000_0000, 4'd9, 64'h4000_0000_0000_0000);
    wait_drain(100);

    // Fill with backpressure, then hold the first result for 10 cycles.
    out_ready = 1'b0;
    for (int t = 0; t < 5; t++) begin
      rx = $urandom;
      ry = $urandom;
      send(rx, ry, TAG_W'(t), ref_mul(rx, ry));
    end
    wait_valid(100);
    tick(10);
    out_ready = 1'b1;
    wait_drain(400);

    // Push on the LOAD->WAIT edge with two entries queued.
    for (int t = 5; t < 8; t++) begin
      rx = $urandom;
      ry = $urandom;
      send(rx, ry, TAG_W'(t), ref_mul(rx, ry));
    end
    wait_drain(300);

    // Reset in the middle of WAIT with requests queued.
    for (int t = 10; t < 13; t++) begin
      rx = $urandom;
      ry = $urandom;
      send(rx, ry, TAG_W'(t), ref_mul(rx, ry));
    end
    tick(9);
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(45);
    send(32'hFFFF_FFFF, 32'h8000_0000, 4'd14, 64'h0000_0000_8000_0000);
    wait_drain(100);

    // Randomized traffic with random consumer backpressure.
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          tick($urandom_range(0, 3));
          rx = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
          ry = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
          send(rx, ry, TAG_W'($urandom_range(0, 15)), ref_mul(rx, ry));
        end
        rnd_done = 1'b1;
      end
      begin
        int g;
        g = 0;
        while ((!rnd_done || exp_q.size() != 0) && g < 20000) begin
          out_ready = ($urandom_range(0, 3) != 0);
          tick(1);
          g++;
        end
        if (exp_q.size() != 0) tmo++;
        out_ready = 1'b1;
      end
    join

    tick(2);
    fin = 1'b1;
    tick(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
